// File: rtl/rx_frame_gate_pkg.sv
// rx_frame_gate_pkg: shared state encoding, counter widths and FIFO entry layout
package rx_frame_gate_pkg;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_TRIG = 2'd1;
  localparam logic [1:0] CAPTURE   = 2'd2;
  localparam int OVF_CNT_W = 16;
  localparam int LAST_POS_FROM_TOP = 0;
  function automatic int cnt_w(input int frame_len);
    return frame_len > 1 ? $clog2(frame_len) : 1;
  endfunction
  function automatic int entry_w(input int dw);
    return dw + 1;
  endfunction
endpackage

// File: rtl/rx_frame_gate_if.sv
// rx_frame_gate_if: AXI-Stream sample/last/ready bundle for the framed output
interface rx_frame_gate_if #(parameter int DW = 16);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/rx_sync_fifo.sv
// rx_sync_fifo: first-word-fall-through FIFO whose head sits in a registered output
module rx_sync_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic         accept,
  output logic         empty,
  output logic         valid,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [AW:0] count, count_n;
  logic pop;
  logic [W-1:0] head_n;
  assign empty   = count == '0;
  assign valid   = !empty;
  assign pop     = valid && rd_en;
  assign accept  = wr_en && (count != (AW+1)'(DEPTH) || pop);
  assign count_n = count + (AW+1)'(accept) - (AW+1)'(pop);
  assign rd_n    = rd_ptr + AW'(pop);
  // when nothing stays behind after the pop, the incoming word becomes the new head
  assign head_n  = count == (AW+1)'(pop) ? din : mem[rd_n];
  // storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end
  // pointers, occupancy and the registered head word
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(accept);
      rd_ptr <= rd_n;
      count  <= count_n;
      if (count_n != '0) dout <= head_n;
    end
  end
endmodule

// File: rtl/rx_frame_gate.sv
// rx_frame_gate: cuts a non-stallable ADC stream into triggered AXI-Stream frames
module rx_frame_gate
  import rx_frame_gate_pkg::*;
#(
  parameter int DW         = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] adc_data,
  input  logic                 adc_valid,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 continuous,
  input  logic                 trig_en,
  input  logic signed [DW-1:0] trig_level,
  input  logic                 clear_ovf,
  rx_frame_gate_if.master      m,
  output logic                 busy,
  output logic                 overflow,
  output logic [OVF_CNT_W-1:0] ovf_cnt
);
  localparam int CW = cnt_w(FRAME_LEN);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic signed [DW-1:0] prev;
  logic prev_valid, trig, last, wr_en, accept, empty;
  assign trig  = prev_valid && prev < trig_level && adc_data >= trig_level;
  assign last  = cnt == CW'(FRAME_LEN - 1);
  assign wr_en = adc_valid && !abort && (state == CAPTURE || (state == WAIT_TRIG && trig));
  assign busy  = state != IDLE || !empty;
  rx_sync_fifo #(.W(entry_w(DW)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .flush(abort),
    .wr_en(wr_en),
    .din({last, adc_data}),
    .rd_en(m.tready),
    .accept(accept),
    .empty(empty),
    .valid(m.tvalid),
    .dout({m.tlast, m.tdata})
  );
  // capture FSM: counter only moves on accepted writes so frames are never short
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      cnt        <= '0;
      prev_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arm) begin
          state      <= trig_en ? WAIT_TRIG : CAPTURE;
          cnt        <= '0;
          prev_valid <= 1'b0;
        end
        WAIT_TRIG: if (adc_valid) begin
          prev       <= adc_data;
          prev_valid <= 1'b1;
          if (accept) begin
            state <= CAPTURE;
            cnt   <= CW'(1);
          end
        end
        CAPTURE: if (accept) begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            state      <= !continuous ? IDLE : trig_en ? WAIT_TRIG : CAPTURE;
            prev_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // sticky overflow flag and saturating drop counter; clearing wins over a new drop
  always_ff @(posedge clk) begin
    if (!reset_n || clear_ovf) begin
      overflow <= 1'b0;
      ovf_cnt  <= '0;
    end else if (wr_en && !accept) begin
      overflow <= 1'b1;
      ovf_cnt  <= ovf_cnt + OVF_CNT_W'(ovf_cnt != '1);
    end
  end
endmodule

// File: tb/tb_rx_frame_gate.sv
// tb_rx_frame_gate: directed and random checks of rx_frame_gate against a queue model
module tb_rx_frame_gate;
  localparam int DW = 16, FL = 8, FD = 4;
  logic clk = 0, reset_n = 0;
  logic signed [DW-1:0] adc_data = 0, trig_level = 0;
  logic adc_valid = 0, arm = 0, abort = 0, continuous = 0, trig_en = 0, clear_ovf = 0;
  logic busy, overflow;
  logic [15:0] ovf_cnt;
  rx_frame_gate_if #(.DW(DW)) m();
  rx_frame_gate #(.DW(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .arm(arm), .abort(abort), .continuous(continuous), .trig_en(trig_en),
    .trig_level(trig_level), .clear_ovf(clear_ovf), .m(m),
    .busy(busy), .overflow(overflow), .ovf_cnt(ovf_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0, passed = 0;
  int mode = 0, pcnt = 0, prev = 0, oc = 0;
  bit hp = 0, ovf = 0;
  logic [DW:0] q[$];
  int gd[$];
  bit gl[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic model_step();
    bit pop, wr, acc, trg, wl;
    if (!reset_n) begin
      mode = 0; pcnt = 0; hp = 0; ovf = 0; oc = 0;
      q.delete();
    end else begin
      pop = q.size() != 0 && m.tready;
      if (abort) begin
        mode = 0; pcnt = 0;
        q.delete();
      end else begin
        trg = hp && prev < int'(trig_level) && int'(adc_data) >= int'(trig_level);
        wr  = adc_valid && (mode == 2 || (mode == 1 && trg));
        wl  = mode == 2 && pcnt == FL - 1;
        acc = wr && (q.size() < FD || pop);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back({wl, adc_data});
        if (wr && !acc) begin
          ovf = 1;
          if (oc < 65535) oc++;
        end
        case (mode)
          0: if (arm) begin mode = trig_en ? 1 : 2; pcnt = 0; hp = 0; end
          1: if (adc_valid) begin
            if (acc) begin mode = 2; pcnt = 1; end
            hp = 1; prev = int'(adc_data);
          end
          2: if (acc) begin
            if (wl) begin pcnt = 0; hp = 0; mode = !continuous ? 0 : (trig_en ? 1 : 2); end
            else pcnt++;
          end
          default: mode = 0;
        endcase
      end
      if (clear_ovf) begin ovf = 0; oc = 0; end
    end
  endtask
  task automatic step();
    if (reset_n && m.tvalid && m.tready) begin
      gd.push_back(int'(m.tdata));
      gl.push_back(m.tlast);
    end
    model_step();
    @(posedge clk);
    #1;
    chk("tvalid", m.tvalid, q.size() != 0);
    if (q.size() != 0) begin
      chk("tdata", m.tdata, q[0][DW-1:0]);
      chk("tlast", m.tlast, q[0][DW]);
    end
    chk("busy", busy, mode != 0 || q.size() != 0);
    chk("overflow", overflow, ovf);
    chk("ovf_cnt", ovf_cnt, oc);
    arm = 0; abort = 0; clear_ovf = 0;
  endtask
  int s[17] = '{120, 130, 140, -50, 20, 99, 150, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
  initial begin
    m.tready = 0;
    repeat (2) step();
    chk("rst_tdata", m.tdata, 0);
    chk("rst_tlast", m.tlast, 0);
    reset_n = 1;
    m.tready = 1;
    gd.delete(); gl.delete();
    for (int i = 0; i < 20; i++) begin
      adc_valid = 1; adc_data = 16'(i); arm = i == 0;
      step();
    end
    adc_valid = 0;
    repeat (4) step();
    chk("single_len", gd.size(), 8);
    if (gd.size() == 8) begin
      chk("single_first", gd[0], 1);
      chk("single_last", gd[7], 8);
      chk("single_tlast7", gl[7], 1);
      chk("single_tlast6", gl[6], 0);
    end
    chk("single_idle", busy, 0);
    gd.delete(); gl.delete();
    trig_en = 1; trig_level = 100;
    for (int i = 0; i < 17; i++) begin
      adc_valid = 1; adc_data = 16'(s[i]); arm = i == 0;
      step();
    end
    adc_valid = 0;
    repeat (4) step();
    chk("trig_len", gd.size(), 8);
    if (gd.size() == 8) begin
      chk("trig_first", gd[0], 150);
      chk("trig_last", gd[7], 16);
      chk("trig_tlast", gl[7], 1);
    end
    trig_en = 0; trig_level = 0;
    gd.delete(); gl.delete();
    arm = 1;
    step();
    m.tready = 0;
    for (int i = 0; i < 10; i++) begin
      adc_valid = 1; adc_data = 16'(200 + i);
      step();
    end
    chk("ovf_flag", overflow, 1);
    chk("ovf_six", ovf_cnt, 6);
    m.tready = 1;
    for (int i = 10; i < 20; i++) begin
      adc_valid = 1; adc_data = 16'(200 + i);
      step();
    end
    adc_valid = 0;
    repeat (8) step();
    chk("ovf_len", gd.size(), 8);
    if (gd.size() == 8) begin
      chk("ovf_resume", gd[4], 210);
      chk("ovf_tlast", gl[7], 1);
    end
    clear_ovf = 1;
    step();
    chk("ovf_clear", ovf_cnt, 0);
    gd.delete(); gl.delete();
    continuous = 1;
    for (int i = 0; i < 32; i++) begin
      adc_valid = 1; adc_data = 16'(300 + i); arm = i == 0;
      step();
    end
    adc_valid = 0; continuous = 0;
    repeat (4) step();
    abort = 1;
    step();
    chk("cont_len", gd.size(), 31);
    for (int k = 0; k < gd.size(); k++) begin
      chk("cont_data", gd[k], 301 + k);
      chk("cont_tlast", gl[k], k % 8 == 7);
    end
    gd.delete(); gl.delete();
    for (int i = 0; i < 20; i++) begin
      adc_valid = 1; adc_data = 16'(400 + i); arm = i == 0;
      step();
      if (gd.size() >= 3) break;
    end
    chk("abort_reach", gd.size(), 3);
    abort = 1; adc_valid = 1;
    step();
    chk("abort_tvalid", m.tvalid, 0);
    chk("abort_busy", busy, 0);
    gd.delete(); gl.delete();
    for (int i = 0; i < 12; i++) begin
      adc_valid = 1; adc_data = 16'(500 + i); arm = i == 0;
      step();
    end
    adc_valid = 0;
    repeat (4) step();
    chk("rearm_len", gd.size(), 8);
    if (gd.size() == 8) chk("rearm_first", gd[0], 501);
    m.tready = 0;
    for (int i = 0; i < 7; i++) begin
      adc_valid = 1; adc_data = 16'(600 + i); arm = i == 0;
      step();
    end
    chk("pre_rst_tvalid", m.tvalid, 1);
    reset_n = 0;
    step();
    chk("rst_mid_tvalid", m.tvalid, 0);
    chk("rst_mid_tdata", m.tdata, 0);
    chk("rst_mid_tlast", m.tlast, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ovf", ovf_cnt, 0);
    reset_n = 1; adc_valid = 0; m.tready = 1;
    repeat (3) step();
    chk("rst_after", m.tvalid, 0);
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        continuous = $urandom_range(0, 1);
        trig_en = $urandom_range(0, 1);
      end
      m.tready = $urandom_range(0, 3) != 0;
      adc_valid = $urandom_range(0, 9) != 0;
      adc_data = 16'($urandom_range(0, 300)) - 16'sd150;
      arm = $urandom_range(0, 15) == 0;
      abort = $urandom_range(0, 79) == 0;
      clear_ovf = $urandom_range(0, 59) == 0;
      step();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
